sub_bytes_iter: RTL and testbench
=================================

Name: sub_bytes_iter

Overview:
- Forward SubBytes engine for the AES encryption datapath. It is the encrypt-side counterpart of the inverse SubBytes stage.
- Accepts a 128-bit state on a valid/ready handshake and substitutes BYTES_PER_CYCLE bytes per clock through a small bank of forward S-boxes. This is time-multiplexed to save area.
- Returns the substituted state on a valid/ready output handshake.
- Sits between AddRoundKey and ShiftRows in the iterative encrypt round controller.

Parameters:
- BYTES_PER_CYCLE, 4, number of S-box instances and bytes substituted per BUSY cycle. Legal values: 1, 2, 4, 8, 16. Any other value is an elaboration error.
- ITERS, 16/BYTES_PER_CYCLE, derived localparam; number of BUSY cycles per block.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_data holds a valid state
- in_ready  output  1  block can accept a state (high only in IDLE)
- in_data  input  128  input state; byte 0 at [127:120], byte 15 at [7:0]
- out_valid  output  1  out_data holds the substituted state
- out_ready  input  1  downstream accepts out_data
- out_data  output  128  substituted state, same byte ordering as in_data
- busy  output  1  high in BUSY or DONE

Behaviour:
- Reset (async assert, state updates on clk after deassert):
  - FSM=IDLE, out_valid=0, out_data=128'h0, busy=0, byte counter=0.
  - in_ready=1 once in IDLE.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge T: latch in_data into the internal state register, set cnt=0, go to BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle, bytes cnt*BYTES_PER_CYCLE .. cnt*BYTES_PER_CYCLE+BYTES_PER_CYCLE-1 (counted from the MSB) pass through the S-boxes and are written back in place. cnt increments.
  - When cnt==ITERS-1, the final write occurs and the FSM goes to DONE.
- DONE:
  - out_valid=1, out_data = state register, held stable until accepted.
  - On out_ready, go to IDLE. out_valid deasserts next cycle.
  - No same-cycle new accept: in_ready rises only the cycle after the handshake.
- Latency: input handshake at edge T gives out_valid high from edge T+ITERS (default: 4 cycles).
- Throughput: one block per ITERS+2 cycles with out_ready tied high.
- Boundary conditions:
  - in_valid while not IDLE is ignored; the input is not sampled, and the upstream must hold it (standard valid/ready).
  - out_ready low in DONE stalls indefinitely; out_data must not change.
  - out_ready high outside DONE has no effect.
  - cnt width is clog2(ITERS), minimum 1 bit.
  - BYTES_PER_CYCLE=16: a single BUSY cycle.
  - rst mid-BUSY or mid-DONE returns the block to the reset values immediately; the partial state is discarded and no out_valid pulse is produced.
- The S-box path is purely combinational; there is no other arithmetic.

Decomposition:
- Shared header aes_defs.vh:
  - AES_STATE_W=128, AES_BYTE_W=8, AES_NUM_BYTES=16.
  - FSM state encodings IDLE/BUSY/DONE, shared with the inverse-direction iterative engine.
- Sub-module sbox: 8-bit combinational forward S-box, FIPS-197 table. It mirrors inv_sbox.
- Instantiate BYTES_PER_CYCLE copies in a generate loop. The byte-select mux and write-back live in sub_bytes_iter.

Test Plan:
- FIPS-197 App. B round 1: in_data=193de3bea0f4e22b9ac68d2ae9f84808 -> out_data=d42711aee0bf98f1b8b45de51e415230, out_valid exactly 4 cycles after accept.
- All-zero then all-FF: 0 -> 63636363...63; FF..FF -> 16161616...16. Also check the single-byte ordering: in_data with byte 0=53 and the rest 00 -> out byte 0=ED, rest 63.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, out_data stable, in_ready stays 0. Then one out_ready pulse -> in_ready=1 next cycle.
- Back-to-back: in_valid held high with two queued states and out_ready=1 -> both results correct and in order, accepts spaced ITERS+2 cycles apart, no state accepted while busy.
- Reset mid-operation: assert rst 2 cycles after accept -> out_valid=0, out_data=0, in_ready=1 after release. A following vector completes correctly.
- Parameter sweep BYTES_PER_CYCLE in {1,2,8,16} with the App. B vector -> same out_data, latency 16/8/2/1 cycles respectively.

Source files
------------

// File: rtl/sub_bytes_iter_pkg.sv
// Shared AES definitions for the iterative SubBytes engines.
// FSM encoding is common to the forward and inverse directions.
package sub_bytes_iter_pkg;

  localparam int AES_STATE_W   = 128;
  localparam int AES_BYTE_W    = 8;
  localparam int AES_NUM_BYTES = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } aes_fsm_e;

  function automatic bit legal_bpc(int n);
    return (n == 1) || (n == 2) || (n == 4) ||
           (n == 8) || (n == 16);
  endfunction

endpackage

// File: rtl/sub_bytes_iter_sbox.sv
// Forward AES S-box, purely combinational table lookup.
// Mirrors inv_sbox on the decrypt side.
module sbox
  import sub_bytes_iter_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] in_byte,
  output logic [AES_BYTE_W-1:0] out_byte
);

  localparam logic [7:0] SBOX_TBL [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_byte = SBOX_TBL[in_byte];

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative forward SubBytes: BYTES_PER_CYCLE S-boxes walk the
// 128-bit state MSB-first, then present it on a valid/ready port.
module sub_bytes_iter
  import sub_bytes_iter_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_data,
  output logic                   busy
);

  localparam int BPC   = BYTES_PER_CYCLE;
  localparam int ITERS = AES_NUM_BYTES / BPC;
  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

  if (!legal_bpc(BYTES_PER_CYCLE)) begin : g_bad_bpc
    $error("sub_bytes_iter: BYTES_PER_CYCLE must be 1/2/4/8/16");
  end

  aes_fsm_e               state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [AES_STATE_W-1:0] data_q, data_d;

  logic [AES_BYTE_W-1:0] lane_in  [BPC];
  logic [AES_BYTE_W-1:0] lane_out [BPC];

  for (genvar g = 0; g < BPC; g++) begin : g_sbox
    sbox u_sbox (
      .in_byte  (lane_in[g]),
      .out_byte (lane_out[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (in_valid)      state_d = ST_BUSY;
      ST_BUSY: if (cnt_q == LAST) state_d = ST_DONE;
      ST_DONE: if (out_ready)     state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // Byte b belongs to iteration b/BPC and lane b%BPC.
  always_comb begin : lane_mux
    for (int i = 0; i < BPC; i++) lane_in[i] = '0;
    for (int b = 0; b < AES_NUM_BYTES; b++) begin
      if (CNT_W'(b / BPC) == cnt_q)
        lane_in[b % BPC] =
          data_q[(AES_NUM_BYTES-1-b)*AES_BYTE_W +: AES_BYTE_W];
    end
  end

  always_comb begin : datapath
    data_d = data_q;
    cnt_d  = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d = in_data;
          cnt_d  = '0;
        end
      end
      ST_BUSY: begin
        for (int b = 0; b < AES_NUM_BYTES; b++) begin
          if (CNT_W'(b / BPC) == cnt_q)
            data_d[(AES_NUM_BYTES-1-b)*AES_BYTE_W +: AES_BYTE_W] =
              lane_out[b % BPC];
        end
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_comb begin : outputs
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q == ST_BUSY) || (state_q == ST_DONE);
    out_data  = (state_q == ST_DONE) ? data_q : '0;
  end

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Self-checking bench for sub_bytes_iter against a GF(2^8)
// S-box model, plus a BYTES_PER_CYCLE latency sweep.
module tb_sub_bytes_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  logic         sw_ov [4];
  logic         sw_ir [4];
  logic         sw_bz [4];
  logic [127:0] sw_od [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sub_bytes_iter #(.BYTES_PER_CYCLE(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  sub_bytes_iter #(.BYTES_PER_CYCLE(1)) dut_b1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sw_ir[0]),
    .in_data(in_data), .out_valid(sw_ov[0]), .out_ready(out_ready),
    .out_data(sw_od[0]), .busy(sw_bz[0])
  );

  sub_bytes_iter #(.BYTES_PER_CYCLE(2)) dut_b2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sw_ir[1]),
    .in_data(in_data), .out_valid(sw_ov[1]), .out_ready(out_ready),
    .out_data(sw_od[1]), .busy(sw_bz[1])
  );

  sub_bytes_iter #(.BYTES_PER_CYCLE(8)) dut_b8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sw_ir[2]),
    .in_data(in_data), .out_valid(sw_ov[2]), .out_ready(out_ready),
    .out_data(sw_od[2]), .busy(sw_bz[2])
  );

  sub_bytes_iter #(.BYTES_PER_CYCLE(16)) dut_b16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sw_ir[3]),
    .in_data(in_data), .out_valid(sw_ov[3]), .out_ready(out_ready),
    .out_data(sw_od[3]), .busy(sw_bz[3])
  );

  // Reference: multiplicative inverse in GF(2^8) then affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    if (x == 8'h00) return 8'h00;
    for (int i = 0; i < 254; i++) r = gmul(r, x);
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
    return (v << k) | (v >> (8 - k));
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] b = ginv(x);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_state(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[127-8*i -: 8] = sbox_ref(s[127-8*i -: 8]);
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drive one accept from IDLE and wait for out_valid (bounded).
  task automatic do_block(input logic [127:0] d,
                          output logic [127:0] res, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    res = out_data;
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    n_checks++;
    if (out_data !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_out_data got %h want 0", out_data);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_fips();
    logic [127:0] v, res, exp_c;
    int lat;
    v     = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    exp_c = 128'hd42711aee0bf98f1b8b45de51e415230;
    do_block(v, res, lat);
    n_checks++;
    if (res !== exp_c) begin
      n_fail++;
      $display("FAIL fips_data got %h want %h", res, exp_c);
    end
    n_checks++;
    if (res !== sub_state(v)) begin
      n_fail++;
      $display("FAIL fips_model got %h want %h", res, sub_state(v));
    end
    n_checks++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL fips_latency got %0d want 4", lat);
    end
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL done_flags busy %b in_ready %b want 1/0",
               busy, in_ready);
    end
    drain();
  endtask

  task automatic test_patterns();
    logic [127:0] vin  [3];
    logic [127:0] vexp [3];
    logic [127:0] res, v;
    int lat;
    vin[0]  = 128'h0;
    vexp[0] = {16{8'h63}};
    vin[1]  = {16{8'hff}};
    vexp[1] = {16{8'h16}};
    vin[2]  = {8'h53, 120'h0};
    vexp[2] = {8'hed, {15{8'h63}}};
    for (int i = 0; i < 3; i++) begin
      do_block(vin[i], res, lat);
      n_checks++;
      if (res !== vexp[i]) begin
        n_fail++;
        $display("FAIL pattern%0d got %h want %h", i, res, vexp[i]);
      end
      drain();
    end
    for (int i = 0; i < 6; i++) begin
      v = rand128();
      do_block(v, res, lat);
      n_checks++;
      if (res !== sub_state(v) || lat !== 4) begin
        n_fail++;
        $display("FAIL random%0d got %h lat %0d want %h lat 4",
                 i, res, lat, sub_state(v));
      end
      drain();
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] v, res;
    int lat;
    int bad = 0;
    v = rand128();
    do_block(v, res, lat);
    in_valid = 1'b1;
    in_data  = ~v;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== res || in_ready !== 1'b0)
        bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stall_hold got %0d bad cycles want 0", bad);
    end
    n_checks++;
    if (res !== sub_state(v)) begin
      n_fail++;
      $display("FAIL stall_data got %h want %h", res, sub_state(v));
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL release in_ready %b out_valid %b busy %b want 1/0/0",
               in_ready, out_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] q [2];
    int acc_cyc [2];
    int n_acc = 0;
    int n_out = 0;
    int overlap = 0;
    bit acc_last = 0;
    q[0] = rand128();
    q[1] = rand128();
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = q[0];
    for (int c = 0; c < 40 && n_out < 2; c++) begin
      if (c > 0) @(negedge clk);
      if (acc_last) begin
        acc_last = 0;
        if (n_acc < 2) in_data = q[n_acc];
        else in_valid = 1'b0;
      end
      if (in_ready && busy) overlap++;
      if (out_valid) begin
        n_checks++;
        if (n_out > 1 || out_data !== sub_state(q[n_out > 1 ? 1 : n_out])) begin
          n_fail++;
          $display("FAIL b2b_out%0d got %h", n_out, out_data);
        end
        n_out++;
      end
      if (in_valid && in_ready) begin
        if (n_acc < 2) acc_cyc[n_acc] = c;
        n_acc++;
        acc_last = 1;
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (n_acc !== 2 || n_out !== 2) begin
      n_fail++;
      $display("FAIL b2b_count got acc %0d out %0d want 2/2", n_acc, n_out);
    end
    n_checks++;
    if (n_acc >= 2 && acc_cyc[1] - acc_cyc[0] !== 6) begin
      n_fail++;
      $display("FAIL b2b_spacing got %0d want 6", acc_cyc[1] - acc_cyc[0]);
    end
    n_checks++;
    if (overlap != 0) begin
      n_fail++;
      $display("FAIL b2b_overlap got %0d want 0", overlap);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] v, res;
    int lat;
    int pulses = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = rand128();
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 128'h0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst ov %b od %h busy %b want 0/0/0",
               out_valid, out_data, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    n_checks++;
    if (pulses != 0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_after pulses %0d in_ready %b want 0/1",
               pulses, in_ready);
    end
    v = rand128();
    do_block(v, res, lat);
    n_checks++;
    if (res !== sub_state(v) || lat !== 4) begin
      n_fail++;
      $display("FAIL midrst_next got %h lat %0d want %h lat 4",
               res, lat, sub_state(v));
    end
    drain();
  endtask

  task automatic test_param_sweep();
    logic [127:0] v, exp_v;
    logic [127:0] res [4];
    int lat [4];
    bit got [4];
    int want [4];
    want = '{16, 8, 2, 1};
    v     = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    exp_v = 128'hd42711aee0bf98f1b8b45de51e415230;
    for (int k = 0; k < 4; k++) begin
      got[k] = 0;
      lat[k] = 0;
      res[k] = '0;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = v;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (!got[k] && sw_ov[k]) begin
          got[k] = 1;
          lat[k] = c;
          res[k] = sw_od[k];
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (res[k] !== exp_v) begin
        n_fail++;
        $display("FAIL sweep%0d_data got %h want %h", want[k], res[k], exp_v);
      end
      n_checks++;
      if (lat[k] !== want[k]) begin
        n_fail++;
        $display("FAIL sweep%0d_latency got %0d want %0d",
                 want[k], lat[k], want[k]);
      end
    end
    drain();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_fips();
    test_patterns();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
